// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder with a registered carry, WIDTH cycles per add, LSB first.
// Optional subtract mode is enabled by defining BSA_SUB_EN (adds the sub port).

// Single full-adder cell driven by the serial datapath.
module bsa_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_fa_b;
  logic             w_fa_s;
  logic             w_fa_c;

`ifdef BSA_SUB_EN
  logic             r_sub_q;
  // Subtraction is a + ~b + 1: invert every b bit, initial carry seeded with sub.
  assign w_fa_b = r_b_sh[0] ^ r_sub_q;
`else
  assign w_fa_b = r_b_sh[0];
`endif

  bsa_fa u_fa (
    .i_a (r_a_sh[0]),
    .i_b (w_fa_b),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // Control FSM and serial datapath; in_ready/out_valid are registered alongside state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= {WIDTH{1'b0}};
      r_b_sh      <= {WIDTH{1'b0}};
      r_sum_sh    <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef BSA_SUB_EN
      r_sub_q     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
`ifdef BSA_SUB_EN
            r_sub_q    <= sub;
            r_carry    <= sub;
`else
            r_carry    <= 1'b0;
`endif
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_sum_sh <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
          r_carry  <= w_fa_c;
          r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_CNT) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_state     <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum_sh;
  assign cout      = r_carry;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: directed cases on WIDTH=8, random streams on WIDTH=8 and 13.
`timescale 1ns/1ps
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_ready8, sub8 = 1'b0, out_valid8, out_ready8 = 1'b1, cout8;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, sum8;
  logic        in_valid13 = 1'b0, in_ready13, sub13 = 1'b0, out_valid13, out_ready13 = 1'b1, cout13;
  logic [12:0] a13 = 13'd0, b13 = 13'd0, sum13;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0]  q8[$];
  logic [13:0] q13[$];
  int acc8 = 0, res8 = 0, acc13 = 0, res13 = 0;
  bit rnd_done = 1'b0;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
`ifdef BSA_SUB_EN
    .sub(sub8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8));

  bit_serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13), .a(a13), .b(b13),
`ifdef BSA_SUB_EN
    .sub(sub13),
`endif
    .out_valid(out_valid13), .out_ready(out_ready13), .sum(sum13), .cout(cout13));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Golden model: {cout,sum}; for subtract cout means no borrow.
  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
`ifdef BSA_SUB_EN
    if (s) return {(x >= y), 8'(x - y)};
`endif
    return {1'b0, x} + {1'b0, y};
  endfunction

  function automatic logic [13:0] model13(input logic [12:0] x, input logic [12:0] y, input logic s);
`ifdef BSA_SUB_EN
    if (s) return {(x >= y), 13'(x - y)};
`endif
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q13.delete();
    end else begin
      if (in_valid8 && in_ready8) begin
        q8.push_back(model8(a8, b8, sub8));
        acc8++;
      end
      if (out_valid8 && out_ready8) begin
        res8++;
        if (q8.size() == 0) check("sb8_unexpected", 64'd1, 64'd0);
        else check("sb8_result", 64'({cout8, sum8}), 64'(q8.pop_front()));
      end
      if (in_valid13 && in_ready13) begin
        q13.push_back(model13(a13, b13, sub13));
        acc13++;
      end
      if (out_valid13 && out_ready13) begin
        res13++;
        if (q13.size() == 0) check("sb13_unexpected", 64'd1, 64'd0);
        else check("sb13_result", 64'({cout13, sum13}), 64'(q13.pop_front()));
      end
    end
  end

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int t;
    in_valid8 = 1'b1; a8 = x; b8 = y; sub8 = s;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready8) break;
      t++;
      if (t > 300) begin check("send8_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic send13(input logic [12:0] x, input logic [12:0] y, input logic s);
    int t;
    in_valid13 = 1'b1; a13 = x; b13 = y; sub13 = s;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready13) break;
      t++;
      if (t > 300) begin check("send13_timeout", 64'd0, 64'd1); break; end
    end
    @(posedge clk); #1;
    in_valid13 = 1'b0;
  endtask

  // Send one operand pair; returns cycles from accept edge to out_valid and the presented result.
  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     output int lat, output logic [8:0] res);
    send8(x, y, s);
    check("rdy_low_in_run", 64'(in_ready8), 64'd0);
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res = {cout8, sum8};
  endtask

  initial begin
    int lat;
    logic [8:0] res, held;
    #2;
    check("rst_out_valid", 64'(out_valid8), 64'd0);
    check("rst_sum", 64'(sum8), 64'd0);
    check("rst_cout", 64'(cout8), 64'd0);
    check("rst_in_ready", 64'(in_ready8), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", 64'(in_ready8), 64'd1);

    // Basic add and latency
    op8(8'h5A, 8'h33, 1'b0, lat, res);
    check("lat_5a33", 64'(lat), 64'd8);
    check("res_5a33", 64'(res), 64'h08D);
    check("rdy_low_done", 64'(in_ready8), 64'd0);
    @(posedge clk); #1;
    check("idle_rdy", 64'(in_ready8), 64'd1);
    check("idle_valid", 64'(out_valid8), 64'd0);

    op8(8'hFF, 8'h01, 1'b0, lat, res);
    check("res_ff01", 64'(res), 64'h100);
    @(posedge clk); #1;
    op8(8'h00, 8'h00, 1'b0, lat, res);
    check("res_0000", 64'(res), 64'h000);
    @(posedge clk); #1;

    // Backpressure: result held, new operands ignored
    out_ready8 = 1'b0;
    op8(8'hC3, 8'h7E, 1'b0, lat, res);
    check("res_c37e", 64'(res), 64'h141);
    held = res;
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      check("bp_hold", 64'({cout8, sum8}), 64'(held));
      check("bp_rdy", 64'(in_ready8), 64'd0);
      check("bp_valid", 64'(out_valid8), 64'd1);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_rdy", 64'(in_ready8), 64'd1);
    check("bp_idle_valid", 64'(out_valid8), 64'd0);
    check("bp_no_capture", 64'(q8.size()), 64'd0);

    // Async reset mid-RUN discards the in-flight result
    send8(8'h77, 8'h11, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid8), 64'd0);
    check("arst_sum", 64'(sum8), 64'd0);
    check("arst_cout", 64'(cout8), 64'd0);
    check("arst_rdy", 64'(in_ready8), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("arst_flush", 64'(q8.size()), 64'd0);
    op8(8'h10, 8'h20, 1'b0, lat, res);
    check("lat_after_rst", 64'(lat), 64'd8);
    check("res_1020", 64'(res), 64'h030);
    @(posedge clk); #1;

`ifdef BSA_SUB_EN
    op8(8'h10, 8'h01, 1'b1, lat, res);
    check("sub_1001", 64'(res), 64'h10F);
    @(posedge clk); #1;
    op8(8'h00, 8'h01, 1'b1, lat, res);
    check("sub_0001", 64'(res), 64'h0FF);
    @(posedge clk); #1;
    op8(8'h10, 8'h01, 1'b0, lat, res);
    check("add_1001", 64'(res), 64'h011);
    @(posedge clk); #1;
`endif

    // Random streams on both widths with random gaps and backpressure
    acc8 = 0; res8 = 0; acc13 = 0; res13 = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send8(8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send13(13'($urandom), 13'($urandom), 1'($urandom));
        end
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready8  = 1'($urandom);
          out_ready13 = 1'($urandom);
        end
      end
      begin
        wait (acc8 == 1000 && acc13 == 1000);
        rnd_done = 1'b1;
      end
    join
    out_ready8 = 1'b1;
    out_ready13 = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (q8.size() == 0 && q13.size() == 0 && !out_valid8 && !out_valid13) break;
      @(posedge clk); #1;
    end
    check("rnd8_drain", 64'(q8.size()), 64'd0);
    check("rnd13_drain", 64'(q13.size()), 64'd0);
    check("rnd8_count", 64'(res8), 64'd1000);
    check("rnd13_count", 64'(res13), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
